// File: rtl/write_ptr_logic.sv
// write_ptr_logic
// Write-domain pointer and flag controller for a dual-clock FIFO. Keeps the
// binary write pointer and a registered Gray copy for the read-side
// synchronizer. Decodes the synchronized Gray read pointer to derive fill
// level, full and almost-full. Writes refused while full are trapped in a
// sticky overflow flag.
module write_ptr_logic #(
    parameter int DEPTH     = 8,
    parameter int PTR_W     = $clog2(DEPTH) + 1,
    parameter int AF_THRESH = 6
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic             w_en,
    input  logic [PTR_W-1:0] gray_r_ptr_syn,
    input  logic             clr_ovf,
    output logic             w_accept,
    output logic [PTR_W-2:0] w_addr,
    output logic [PTR_W-1:0] bin_w_ptr,
    output logic [PTR_W-1:0] gray_w_ptr,
    output logic [PTR_W-1:0] bin_r_ptr,
    output logic             full,
    output logic             almost_full,
    output logic [PTR_W-1:0] wr_level,
    output logic             overflow
);

    logic [PTR_W-1:0] r_bin_w_ptr;
    logic [PTR_W-1:0] r_gray_w_ptr;
    logic             r_overflow;

    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_bin_r_ptr;
    logic [PTR_W-1:0] w_level;
    logic             w_full;
    logic             w_accept_int;

    // Gray-to-binary decode of the synchronized read pointer: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_bin_r_ptr = '0;
        for (int i = 0; i < PTR_W; i++) begin
            w_bin_r_ptr[i] = ^(gray_r_ptr_syn >> i);
        end
    end

    // Occupancy, full and write acceptance, all judged on current register and read-pointer values
    always_comb begin
        w_level      = r_bin_w_ptr - w_bin_r_ptr;
        w_full       = (r_bin_w_ptr[PTR_W-1] != w_bin_r_ptr[PTR_W-1]) &&
                       (r_bin_w_ptr[PTR_W-2:0] == w_bin_r_ptr[PTR_W-2:0]);
        w_accept_int = w_en && !w_full;
        w_bin_next   = r_bin_w_ptr + PTR_W'(1);
    end

    // Pointer registers; the Gray copy is loaded from the incremented binary value so only one bit toggles per write
    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_bin_w_ptr  <= '0;
            r_gray_w_ptr <= '0;
        end else if (w_accept_int) begin
            r_bin_w_ptr  <= w_bin_next;
            r_gray_w_ptr <= w_bin_next ^ (w_bin_next >> 1);
        end
    end

    // Sticky overflow: a refused write sets it and takes priority over a simultaneous clear
    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_accept    = w_accept_int;
    assign w_addr      = r_bin_w_ptr[PTR_W-2:0];
    assign bin_w_ptr   = r_bin_w_ptr;
    assign gray_w_ptr  = r_gray_w_ptr;
    assign bin_r_ptr   = w_bin_r_ptr;
    assign full        = w_full;
    assign almost_full = (w_level >= PTR_W'(AF_THRESH));
    assign wr_level    = w_level;
    assign overflow    = r_overflow;

endmodule
